multi_blinker: RTL and testbench

- Parametrised successor to the single fixed-offset blinker.
- Drives NUM_CH independent LED channels from one shared prescaled tick.
- Each channel has runtime-configurable mode, period, on-time and phase offset, loaded through a valid/ready config port.
- Sits between the top-level pin wrapper and uo_out/uio_out bits.

---
 rtl/blink_pkg.sv | 19 +
 rtl/blink_channel.sv | 128 ++++++++++++
 rtl/multi_blinker.sv | 88 ++++++++
 tb/tb_multi_blinker.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared definitions for the multi-channel LED blinker.
//   mode_e : per-channel operating mode (2-bit encoding matches cfg_mode).
//   ch_w() : width of a channel-select field for a given channel count
//            (never narrower than 1 bit, so a single-channel build still
//            has a usable cfg_ch port).
package blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_e;

    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/blink_channel.sv
// One LED channel: config registers, phase counter, registered output and
// ONESHOT completion strobe.
//
// Ports
//   clk, rst       : system clock, synchronous active-high reset
//   tick_i         : shared prescaler strobe, advances the phase
//   cfg_we_i       : config write for this channel (already decoded)
//   cfg_mode_i     : new mode
//   cfg_period_i   : new period in ticks (0 behaves as 1)
//   cfg_on_i       : new high time in ticks
//   cfg_offset_i   : new starting phase
//   led_o          : registered LED level
//   done_o         : 1-cycle strobe when a ONESHOT finishes
//
// mode         | meaning
// -------------+--------------------------------------------------------
// MODE_OFF     | led low, phase held at 0
// MODE_ON      | led high, phase held at 0
// MODE_BLINK   | led = phase < on, phase wraps at eff_period
// MODE_ONESHOT | led = phase < on, phase counts up; drops to OFF when done
module blink_channel
    import blink_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             cfg_we_i,
    input  mode_e            cfg_mode_i,
    input  logic [CNT_W-1:0] cfg_period_i,
    input  logic [CNT_W-1:0] cfg_on_i,
    input  logic [CNT_W-1:0] cfg_offset_i,
    output logic             led_o,
    output logic             done_o
);

    // The offset is folded into the phase at load time, so only the fields
    // that stay live afterwards are kept.
    typedef struct packed {
        mode_e            mode;
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] on;
    } ch_cfg_t;

    localparam logic [CNT_W:0] INC_ONE = (CNT_W+1)'(1);

    ch_cfg_t          cfg_q, cfg_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic             led_q, led_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] eff_period;
    logic [CNT_W-1:0] new_eff_period;
    logic [CNT_W:0]   phase_inc;

    always_comb begin
        cfg_d          = cfg_q;
        phase_d        = phase_q;
        done_d         = 1'b0;
        led_d          = 1'b0;
        eff_period     = (cfg_q.period == '0) ? CNT_W'(1) : cfg_q.period;
        new_eff_period = (cfg_period_i == '0) ? CNT_W'(1) : cfg_period_i;
        // One bit wider than the phase so the +1 can never wrap.
        phase_inc      = {1'b0, phase_q} + INC_ONE;

        if (cfg_we_i) begin
            // A write replaces everything, cancels a running ONESHOT and
            // swallows a coincident tick.
            cfg_d.mode   = cfg_mode_i;
            cfg_d.period = cfg_period_i;
            cfg_d.on     = cfg_on_i;
            if ((cfg_mode_i == MODE_BLINK || cfg_mode_i == MODE_ONESHOT) &&
                (cfg_offset_i < new_eff_period)) begin
                phase_d = cfg_offset_i;
            end else begin
                phase_d = '0;
            end
        end else if (tick_i) begin
            case (cfg_q.mode)
                MODE_BLINK: begin
                    if (phase_inc >= {1'b0, eff_period}) begin
                        phase_d = '0;
                    end else begin
                        phase_d = phase_inc[CNT_W-1:0];
                    end
                end
                MODE_ONESHOT: begin
                    // >= also covers on=0 and a start offset at/after on.
                    if (phase_inc >= {1'b0, cfg_q.on}) begin
                        cfg_d.mode = MODE_OFF;
                        phase_d    = '0;
                        done_d     = 1'b1;
                    end else begin
                        phase_d = phase_inc[CNT_W-1:0];
                    end
                end
                default: phase_d = '0;
            endcase
        end

        // Output is computed from the next state so it appears the cycle
        // right after the state changes.
        case (cfg_d.mode)
            MODE_OFF: led_d = 1'b0;
            MODE_ON:  led_d = 1'b1;
            default:  led_d = (phase_d < cfg_d.on);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q   <= '0;
            phase_q <= '0;
            led_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cfg_q   <= cfg_d;
            phase_q <= phase_d;
            led_q   <= led_d;
            done_q  <= done_d;
        end
    end

    assign led_o  = led_q;
    assign done_o = done_q;

endmodule

// File: rtl/multi_blinker.sv
// NUM_CH independent LED channels driven from one shared prescaled tick,
// each configured at runtime through a valid/ready write port.
//
// Ports
//   clk, rst    : system clock, synchronous active-high reset
//   en          : global run enable; low freezes tick and all phases
//   cfg_valid   : config write request
//   cfg_ready   : config accept (low only while in reset)
//   cfg_ch      : target channel; values >= NUM_CH are dropped
//   cfg_mode    : 0=OFF 1=ON 2=BLINK 3=ONESHOT
//   cfg_period  : blink period in ticks
//   cfg_on      : high time in ticks
//   cfg_offset  : starting phase
//   led_out     : registered channel outputs
//   pulse_done  : per-channel ONESHOT completion strobe
//   tick        : prescaler strobe (debug)
module multi_blinker
    import blink_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 16,
    parameter int PRESCALE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [ch_w(NUM_CH)-1:0]  cfg_ch,
    input  logic [1:0]               cfg_mode,
    input  logic [CNT_W-1:0]         cfg_period,
    input  logic [CNT_W-1:0]         cfg_on,
    input  logic [CNT_W-1:0]         cfg_offset,
    output logic [NUM_CH-1:0]        led_out,
    output logic [NUM_CH-1:0]        pulse_done,
    output logic                     tick
);

    localparam int CH_W = ch_w(NUM_CH);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] ps_q, ps_d;
    logic            ps_wrap;
    logic            cfg_fire;

    assign ps_wrap   = (ps_q == PS_W'(PRESCALE - 1));
    assign tick      = en & ~rst & ps_wrap;
    assign cfg_ready = ~rst;
    assign cfg_fire  = cfg_valid & cfg_ready;

    always_comb begin
        ps_d = ps_q;
        if (en) begin
            ps_d = ps_wrap ? '0 : ps_q + PS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic we;

        // An out-of-range cfg_ch matches no channel, so the write is lost.
        assign we = cfg_fire & (cfg_ch == CH_W'(i));

        blink_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .tick_i       (tick),
            .cfg_we_i     (we),
            .cfg_mode_i   (mode_e'(cfg_mode)),
            .cfg_period_i (cfg_period),
            .cfg_on_i     (cfg_on),
            .cfg_offset_i (cfg_offset),
            .led_o        (led_out[i]),
            .done_o       (pulse_done[i])
        );
    end

endmodule

// File: tb/tb_multi_blinker.sv
module tb_multi_blinker;
    import blink_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       cfg_valid = 1'b0;
    logic       cfg_valid5 = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [2:0] cfg_ch5 = '0;
    logic [1:0] cfg_mode = '0;
    logic [7:0] cfg_period = '0, cfg_on = '0, cfg_offset = '0;

    logic       cfg_ready, tick, cfg_ready3, tick3, cfg_ready5, tick5;
    logic [3:0] led_out, pulse_done, led3, done3;
    logic [4:0] led5, done5;

    int passed = 0;
    int total  = 0;

    multi_blinker #(.NUM_CH(4), .CNT_W(8), .PRESCALE(1)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_on(cfg_on),
        .cfg_offset(cfg_offset), .led_out(led_out), .pulse_done(pulse_done), .tick(tick));

    multi_blinker #(.NUM_CH(4), .CNT_W(8), .PRESCALE(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready3),
        .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_on(cfg_on),
        .cfg_offset(cfg_offset), .led_out(led3), .pulse_done(done3), .tick(tick3));

    multi_blinker #(.NUM_CH(5), .CNT_W(8), .PRESCALE(1)) dut5 (
        .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid5), .cfg_ready(cfg_ready5),
        .cfg_ch(cfg_ch5), .cfg_mode(cfg_mode), .cfg_period(cfg_period), .cfg_on(cfg_on),
        .cfg_offset(cfg_offset), .led_out(led5), .pulse_done(done5), .tick(tick5));

    typedef struct {
        string      name;
        int         ch;
        logic [1:0] mode;
        logic [7:0] period;
        logic [7:0] on;
        logic [7:0] offset;
        logic [7:0] led_pat;   // bit k = led[ch] k cycles after the write edge
        logic [7:0] done_pat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_valid = 1'b0; cfg_valid5 = 1'b0; en = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] ch, input logic [1:0] mode,
                           input logic [7:0] p, input logic [7:0] o, input logic [7:0] off);
        cfg_valid = 1'b1; cfg_ch = ch; cfg_mode = mode;
        cfg_period = p; cfg_on = o; cfg_offset = off;
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{"blink_p4_on1",   0, 2'(MODE_BLINK),   8'd4, 8'd1, 8'd0, 8'b0001_0001, 8'h00};
        vecs[1]  = '{"blink_off2",     1, 2'(MODE_BLINK),   8'd4, 8'd2, 8'd2, 8'b1100_1100, 8'h00};
        vecs[2]  = '{"oneshot_on3",    2, 2'(MODE_ONESHOT), 8'd8, 8'd3, 8'd0, 8'b0000_0111, 8'b0000_1000};
        vecs[3]  = '{"on_gt_period",   3, 2'(MODE_BLINK),   8'd4, 8'd5, 8'd0, 8'hFF,        8'h00};
        vecs[4]  = '{"period0",        0, 2'(MODE_BLINK),   8'd0, 8'd1, 8'd0, 8'hFF,        8'h00};
        vecs[5]  = '{"blink_on0",      1, 2'(MODE_BLINK),   8'd4, 8'd0, 8'd0, 8'h00,        8'h00};
        vecs[6]  = '{"oneshot_off_ge", 3, 2'(MODE_ONESHOT), 8'd8, 8'd2, 8'd3, 8'h00,        8'b0000_0010};
        vecs[7]  = '{"oneshot_on0",    0, 2'(MODE_ONESHOT), 8'd8, 8'd0, 8'd0, 8'h00,        8'b0000_0010};
        vecs[8]  = '{"mode_on",        2, 2'(MODE_ON),      8'd4, 8'd2, 8'd0, 8'hFF,        8'h00};
        vecs[9]  = '{"offset_big",     0, 2'(MODE_BLINK),   8'd4, 8'd1, 8'd6, 8'b0001_0001, 8'h00};
        vecs[10] = '{"blink_p3_off1",  3, 2'(MODE_BLINK),   8'd3, 8'd2, 8'd1, 8'b0110_1101, 8'h00};

        // Reset with a pending config request.
        rst = 1'b1;
        set_cfg(2'd0, 2'(MODE_ON), 8'd0, 8'd0, 8'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_ready",   32'(cfg_ready), 32'd0);
            check("rst_led",     32'(led_out),   32'd0);
            check("rst_done",    32'(pulse_done), 32'd0);
            check("rst_tick",    32'(tick),      32'd0);
            check("rst_led3",    32'(led3),      32'd0);
            check("rst_ready5",  32'(cfg_ready5), 32'd0);
        end
        rst = 1'b0; cfg_valid = 1'b0;
        #1;
        check("ready_after_rst", 32'(cfg_ready), 32'd1);
        check("ready3_after_rst", 32'(cfg_ready3), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_led", 32'(led_out), 32'd0);
        end

        // Table-driven single-channel patterns.
        foreach (vecs[n]) begin
            do_reset();
            set_cfg(2'(vecs[n].ch), vecs[n].mode, vecs[n].period, vecs[n].on, vecs[n].offset);
            step();
            cfg_valid = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (k > 0) step();
                check({vecs[n].name, "_led"},  32'(led_out),
                      32'(vecs[n].led_pat[k]) << vecs[n].ch);
                check({vecs[n].name, "_done"}, 32'(pulse_done),
                      32'(vecs[n].done_pat[k]) << vecs[n].ch);
            end
        end

        // PRESCALE=3: ch1 period4 on2 offset2; tick on every third cycle.
        do_reset();
        set_cfg(2'd1, 2'(MODE_BLINK), 8'd4, 8'd2, 8'd2);
        step();
        cfg_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            int n;
            if (k > 0) step();
            n = (k + 1) / 3;
            check("ps3_tick", 32'(tick3), 32'((k % 3) == 1));
            check("ps3_led",  32'(led3),  32'(((2 + n) % 4) < 2) << 1);
            check("ps3_done", 32'(done3), 32'd0);
        end

        // Out-of-range channel select on a 5-channel build.
        do_reset();
        cfg_valid5 = 1'b1; cfg_ch5 = 3'd7; cfg_mode = 2'(MODE_ON);
        cfg_period = 8'd4; cfg_on = 8'd1; cfg_offset = 8'd0;
        step();
        check("ch7_ignored", 32'(led5), 32'd0);
        cfg_ch5 = 3'd5;
        step();
        check("ch5_ignored", 32'(led5), 32'd0);
        cfg_ch5 = 3'd4;
        step();
        cfg_valid5 = 1'b0;
        check("ch4_written", 32'(led5), 32'b10000);
        check("ch4_nodone",  32'(done5), 32'd0);
        check("ch4_tick",    32'(tick5), 32'd1);

        // Mid-operation rewrite coincident with a tick, en freeze, rst.
        do_reset();
        set_cfg(2'd0, 2'(MODE_BLINK), 8'd4, 8'd1, 8'd0); step();
        set_cfg(2'd1, 2'(MODE_BLINK), 8'd4, 8'd2, 8'd0); step();
        cfg_valid = 1'b0;
        step(); step(); step();
        set_cfg(2'd0, 2'(MODE_BLINK), 8'd4, 8'd1, 8'd3); step();
        cfg_valid = 1'b0;
        check("rewrite_s5", 32'(led_out), 32'b0010);
        step(); check("rewrite_s6", 32'(led_out), 32'b0011);
        step(); check("rewrite_s7", 32'(led_out), 32'b0000);
        step(); check("rewrite_s8", 32'(led_out), 32'b0000);
        step(); check("rewrite_s9", 32'(led_out), 32'b0010);
        en = 1'b0;
        step(); check("en0_s10", 32'(led_out), 32'b0010); check("en0_tick", 32'(tick), 32'd0);
        step(); check("en0_s11", 32'(led_out), 32'b0010);
        set_cfg(2'd2, 2'(MODE_ON), 8'd0, 8'd0, 8'd0);
        step(); cfg_valid = 1'b0;
        check("en0_cfg_s12", 32'(led_out), 32'b0110);
        step(); check("en0_s13", 32'(led_out), 32'b0110);
        step(); check("en0_s14", 32'(led_out), 32'b0110);
        en = 1'b1;
        step(); check("resume_s15", 32'(led_out), 32'b0111);
        rst = 1'b1;
        step();
        check("midrst_led",   32'(led_out),    32'd0);
        check("midrst_done",  32'(pulse_done), 32'd0);
        check("midrst_ready", 32'(cfg_ready),  32'd0);
        rst = 1'b0;
        step();
        check("post_rst_led", 32'(led_out), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
